mini_alu_exec: RTL and testbench
================================

Name: mini_alu_exec

Overview:
- Parametrised, handshaked execute unit for the MiniAlu processor family.
- Replaces the purely combinational opcode case with a registered single-cycle path and an iterative multi-cycle multiplier.
- Width is generic, and results are either DATA_WIDTH or 2*DATA_WIDTH wide.
- Sits between decode/operand-forwarding and register-file writeback; the branch request goes to the IP counter and the LED request to the LED register.

Parameters:
DATA_WIDTH, 16, operand width; wide results are 2*DATA_WIDTH.
ADDR_WIDTH, 8, destination/branch-target address width.
SATURATE, 0, 1 = ADD/SUB clamp to the signed DATA_WIDTH range instead of wrapping.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
iValid  in  1  operation presented
oReady  out  1  unit can accept an operation this cycle
iOperation  in  4  opcode (package constants)
iDest  in  ADDR_WIDTH  write address or branch target
iOperandA  in  2*DATA_WIDTH  source 0 (low DATA_WIDTH used by narrow ops)
iOperandB  in  2*DATA_WIDTH  source 1
iImmediate  in  DATA_WIDTH  immediate for STO
oValid  out  1  result/request valid
iResultReady  in  1  downstream accepts the result
oDest  out  ADDR_WIDTH  registered iDest
oResult  out  2*DATA_WIDTH  result (narrow results zero-extended)
oWriteEnable  out  1  narrow register write
oWriteEnableWide  out  1  wide register write
oBranchTaken  out  1  branch/jump request, target = oDest
oLedEnable  out  1  LED register load of oResult[7:0]
oIllegal  out  1  undefined opcode flag
oBusy  out  1  multiplier iterating

Behaviour:
- Reset (Reset=0, async): all outputs 0, FSM in IDLE, multiplier registers cleared.
- Accept occurs on a cycle with iValid && oReady. oReady = (state==IDLE) && (!oValid || iResultReady).
- Single-cycle ops: output register loads on the accept edge. oValid=1 the next cycle (latency 1). Output holds stable while oValid && !iResultReady.
- Output register clears oValid on a cycle with iResultReady && no new accept.
- NOP: oValid=1, all enables 0, oResult=0.
- ADD/SUB: B+A / B−A on DATA_WIDTH bits, oWriteEnable=1.
  - SATURATE=1: a signed overflow clamps to 0x7FFF/0x8000 (for W=16).
- ADD_W/SUB_W: the same on 2*DATA_WIDTH bits, oWriteEnableWide=1, never saturate.
- STO: oResult = iImmediate, oWriteEnable=1.
- BLE: oBranchTaken = (B <= A) unsigned, DATA_WIDTH compare.
- JMP: oBranchTaken=1.
- LED: oLedEnable=1, oResult = B.
- Any other opcode: oValid=1, oIllegal=1, all enables 0.
- SMUL/UMUL follow the multiplier FSM below.
  - State IDLE: on accept, latch |A|,|B| (SMUL) or A,B (UMUL), sign = A[W-1]^B[W-1] (SMUL only), count=0. Go to MUL.
  - State MUL: radix-2 shift-add, one bit per cycle. count increments; after DATA_WIDTH iterations go to DONE. oBusy=1 in MUL.
  - State DONE: load the output register with the product, two's-complement negated when sign=1. oWriteEnableWide=1, oValid=1 next cycle. Return to IDLE.
  - Latency: oValid asserts DATA_WIDTH+2 cycles after the accept edge.
- Boundary cases:
  - SMUL of −2^(W−1) × −2^(W−1) gives +2^(2W−2), which is exact (the magnitude fits in W bits unsigned).
  - Multiply by 0 still takes the full latency.
  - A DONE result waiting on backpressure stays in DONE until the output register is free.
  - Accept and downstream consume in the same cycle is legal (back-to-back, throughput 1/cycle for single-cycle ops).
  - Reset asserted mid-multiply aborts: state returns to IDLE, oValid=0.
- At most one of oWriteEnable, oWriteEnableWide, oBranchTaken, oLedEnable is 1.

Decomposition:
- Package mini_alu_pkg holds the opcode constants:
  - NOP=0, LED=1, BLE=2, STO=3, ADD=4, JMP=5, SUB=6, SMUL=7, ADD_W=8, SUB_W=9, UMUL=10.
  - FSM state encoding IDLE/MUL/DONE.
- One sub-module, mini_alu_seq_mult, holds the iterative multiplier (start/done handshake, signed mode input).
- Decode, saturation and the output register stay in the top module.

Test Plan (DATA_WIDTH=16):
- Reset sequence:
  - Reset=0 mid-SMUL (cycle 5) -> oValid=0, oBusy=0, oReady=1 after release.
  - A new ADD 3+4 then produces oResult=7.
- Back-to-back single-cycle ops:
  - ADD 0x0005+0x0003, SUB B=0x0003/A=0x0005, STO 0x1234 with iResultReady=1 -> oResult 0x0008, 0xFFFE, 0x1234 on three consecutive cycles, oWriteEnable=1 each.
- Multiplies:
  - SMUL A=0xFFFE(−2), B=0x0003 -> oResult=0xFFFFFFFA exactly 18 cycles after accept, oWriteEnableWide=1.
  - SMUL 0x8000×0x8000 -> 0x40000000.
  - UMUL 0xFFFF×0xFFFF -> 0xFFFE0001.
- Backpressure:
  - iResultReady=0 for 4 cycles after an ADD -> oResult/oValid stable, oReady=0.
  - Release -> the next op is accepted the same cycle.
- Saturation (SATURATE=1):
  - ADD 0x7FFF+0x0001 -> 0x7FFF.
  - SUB B=0x8000/A=0x0001 -> 0x8000.
  - With SATURATE=0, the same ADD gives 0x8000.
- Control ops:
  - BLE B=2/A=2, iDest=0x40 -> oBranchTaken=1, oDest=0x40.
  - BLE B=3/A=2 -> oBranchTaken=0.
  - LED B=0x00A5 -> oLedEnable=1, oResult[7:0]=0xA5.
  - Opcode 0xF -> oIllegal=1, no enables.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// Shared opcode, FSM-state and output-flag definitions for the MiniAlu execute unit.
package mini_alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LED   = 4'd1;
    localparam logic [3:0] OP_BLE   = 4'd2;
    localparam logic [3:0] OP_STO   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SMUL  = 4'd7;
    localparam logic [3:0] OP_ADD_W = 4'd8;
    localparam logic [3:0] OP_SUB_W = 4'd9;
    localparam logic [3:0] OP_UMUL  = 4'd10;

    // Multiplier sequencer states, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic we;
        logic we_wide;
        logic branch;
        logic led;
        logic illegal;
    } out_flags_t;

    localparam out_flags_t FLAGS_WIDE = '{we: 1'b0, we_wide: 1'b1, branch: 1'b0, led: 1'b0, illegal: 1'b0};

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_SMUL) || (op == OP_UMUL);
    endfunction

endpackage

// File: rtl/mini_alu_exec_if.sv
// Operation/result handshake bundle between decode, the execute unit and writeback.
interface mini_alu_exec_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                    iValid;
    logic                    oReady;
    logic [3:0]              iOperation;
    logic [ADDR_WIDTH-1:0]   iDest;
    logic [2*DATA_WIDTH-1:0] iOperandA;
    logic [2*DATA_WIDTH-1:0] iOperandB;
    logic [DATA_WIDTH-1:0]   iImmediate;
    logic                    oValid;
    logic                    iResultReady;
    logic [ADDR_WIDTH-1:0]   oDest;
    logic [2*DATA_WIDTH-1:0] oResult;
    logic                    oWriteEnable;
    logic                    oWriteEnableWide;
    logic                    oBranchTaken;
    logic                    oLedEnable;
    logic                    oIllegal;
    logic                    oBusy;

    modport master (
        output iValid, iOperation, iDest, iOperandA, iOperandB, iImmediate, iResultReady,
        input  oReady, oValid, oDest, oResult, oWriteEnable, oWriteEnableWide,
               oBranchTaken, oLedEnable, oIllegal, oBusy
    );

    modport slave (
        input  iValid, iOperation, iDest, iOperandA, iOperandB, iImmediate, iResultReady,
        output oReady, oValid, oDest, oResult, oWriteEnable, oWriteEnableWide,
               oBranchTaken, oLedEnable, oIllegal, oBusy
    );

endinterface

// File: rtl/mini_alu_seq_mult.sv
// Iterative radix-2 shift-add multiplier, one multiplier bit per cycle, with optional
// signed mode via sign/magnitude. The product is held in DONE until take_i.
module mini_alu_seq_mult
    import mini_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               take_i,
    output logic               idle_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // The magnitude of -2^(W-1) is 2^(W-1), which still fits as an unsigned W-bit value.
    assign mag_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_MUL;
                    count_d  = '0;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                end
            end
            ST_MUL: begin
                if (count_q == CW'(WIDTH)) begin
                    state_d = ST_DONE;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (take_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    assign idle_o    = (state_q == ST_IDLE);
    assign busy_o    = (state_q == ST_MUL);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/mini_alu_exec.sv
// MiniAlu execute unit: decodes an accepted operation into a registered result with
// write/branch/LED requests; multiplies go through the iterative sequencer.
module mini_alu_exec
    import mini_alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    mini_alu_exec_if.slave   bus
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned RW = 2 * DATA_WIDTH;

    logic [W-1:0]          a_n, b_n;
    logic [W-1:0]          add_n, sub_n, clamp_n;
    logic                  add_ovf, sub_ovf;
    logic                  out_free, accept, accept_mul, mul_take;
    logic                  mul_idle, mul_busy, mul_done;
    logic [RW-1:0]         mul_product;
    logic [RW-1:0]         dec_result;
    out_flags_t            dec_flags;

    logic                  valid_q;
    logic [RW-1:0]         result_q;
    logic [ADDR_WIDTH-1:0] dest_q;
    logic [ADDR_WIDTH-1:0] mul_dest_q;
    out_flags_t            flags_q;

    assign a_n = bus.iOperandA[W-1:0];
    assign b_n = bus.iOperandB[W-1:0];

    // A slot is free when empty or when the held result is consumed this very cycle.
    assign out_free   = !valid_q || bus.iResultReady;
    assign bus.oReady = mul_idle && out_free;
    assign accept     = bus.iValid && bus.oReady;
    assign accept_mul = accept && is_mul_op(bus.iOperation);
    assign mul_take   = mul_done && out_free;

    assign add_n   = b_n + a_n;
    assign sub_n   = b_n - a_n;
    assign add_ovf = (a_n[W-1] == b_n[W-1]) && (add_n[W-1] != b_n[W-1]);
    assign sub_ovf = (a_n[W-1] != b_n[W-1]) && (sub_n[W-1] != b_n[W-1]);
    // Overflow always lands on the side of B's sign, so B picks the rail.
    assign clamp_n = b_n[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    always_comb begin
        dec_result = '0;
        dec_flags  = '0;
        case (bus.iOperation)
            OP_NOP: ;
            OP_LED: begin
                dec_flags.led = 1'b1;
                dec_result    = {{W{1'b0}}, b_n};
            end
            OP_BLE: dec_flags.branch = (b_n <= a_n);
            OP_STO: begin
                dec_flags.we = 1'b1;
                dec_result   = {{W{1'b0}}, bus.iImmediate};
            end
            OP_ADD: begin
                dec_flags.we = 1'b1;
                dec_result   = {{W{1'b0}}, (SATURATE && add_ovf) ? clamp_n : add_n};
            end
            OP_JMP: dec_flags.branch = 1'b1;
            OP_SUB: begin
                dec_flags.we = 1'b1;
                dec_result   = {{W{1'b0}}, (SATURATE && sub_ovf) ? clamp_n : sub_n};
            end
            OP_ADD_W: begin
                dec_flags.we_wide = 1'b1;
                dec_result        = bus.iOperandB + bus.iOperandA;
            end
            OP_SUB_W: begin
                dec_flags.we_wide = 1'b1;
                dec_result        = bus.iOperandB - bus.iOperandA;
            end
            OP_SMUL, OP_UMUL: ;
            default: dec_flags.illegal = 1'b1;
        endcase
    end

    mini_alu_seq_mult #(
        .WIDTH(W)
    ) u_mult (
        .clk       (Clock),
        .rst_n     (Reset),
        .start_i   (accept_mul),
        .signed_i  (bus.iOperation == OP_SMUL),
        .a_i       (a_n),
        .b_i       (b_n),
        .take_i    (mul_take),
        .idle_o    (mul_idle),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Single-cycle loads and multiplier takes are exclusive: accept needs IDLE, take needs DONE.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            dest_q     <= '0;
            mul_dest_q <= '0;
            flags_q    <= '0;
        end else begin
            if (accept_mul) mul_dest_q <= bus.iDest;
            if (accept && !accept_mul) begin
                valid_q  <= 1'b1;
                result_q <= dec_result;
                dest_q   <= bus.iDest;
                flags_q  <= dec_flags;
            end else if (mul_take) begin
                valid_q  <= 1'b1;
                result_q <= mul_product;
                dest_q   <= mul_dest_q;
                flags_q  <= FLAGS_WIDE;
            end else if (bus.iResultReady) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign bus.oValid           = valid_q;
    assign bus.oResult          = result_q;
    assign bus.oDest            = dest_q;
    assign bus.oWriteEnable     = valid_q & flags_q.we;
    assign bus.oWriteEnableWide = valid_q & flags_q.we_wide;
    assign bus.oBranchTaken     = valid_q & flags_q.branch;
    assign bus.oLedEnable       = valid_q & flags_q.led;
    assign bus.oIllegal         = valid_q & flags_q.illegal;
    assign bus.oBusy            = mul_busy;

endmodule

// File: tb/tb_mini_alu_exec.sv
// Directed bench for mini_alu_exec: one wrapping and one saturating instance share stimulus.
module tb_mini_alu_exec;

    localparam int DW = 16;
    localparam int AW = 8;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    mini_alu_exec_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mini_alu_exec_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_sat ();

    assign bus_sat.iValid       = bus.iValid;
    assign bus_sat.iOperation   = bus.iOperation;
    assign bus_sat.iDest        = bus.iDest;
    assign bus_sat.iOperandA    = bus.iOperandA;
    assign bus_sat.iOperandB    = bus.iOperandB;
    assign bus_sat.iImmediate   = bus.iImmediate;
    assign bus_sat.iResultReady = bus.iResultReady;

    mini_alu_exec #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SATURATE(1'b0)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    mini_alu_exec #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SATURATE(1'b1)) dut_sat (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_sat)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] imm, input logic [7:0] dest);
        bus.iValid     = 1'b1;
        bus.iOperation = op;
        bus.iOperandA  = a;
        bus.iOperandB  = b;
        bus.iImmediate = imm;
        bus.iDest      = dest;
    endtask

    task automatic set_idle();
        bus.iValid     = 1'b0;
        bus.iOperation = 4'd0;
        bus.iOperandA  = '0;
        bus.iOperandB  = '0;
        bus.iImmediate = '0;
        bus.iDest      = '0;
    endtask

    // Issues one multiply and counts edges from the accept edge to the first oValid.
    task automatic run_mul(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] res, output int lat, output logic wide, output logic busy_mid);
        set_op(op, {16'h0, a}, {16'h0, b}, 16'h0, 8'h21);
        step();
        set_idle();
        lat = 0;
        busy_mid = 1'b0;
        while (lat < 40) begin
            step();
            lat++;
            if (lat == 3) busy_mid = bus.oBusy;
            if (bus.oValid) break;
        end
        res  = bus.oResult;
        wide = bus.oWriteEnableWide;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.iResultReady = 1'b1;
        set_idle();
        #12;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.oValid); end
        checks++; if (bus.oResult !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.oResult); end
        checks++; if ({bus.oWriteEnable, bus.oWriteEnableWide, bus.oBranchTaken, bus.oLedEnable, bus.oIllegal, bus.oBusy} !== 6'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 000000",
                {bus.oWriteEnable, bus.oWriteEnableWide, bus.oBranchTaken, bus.oLedEnable, bus.oIllegal, bus.oBusy}); end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_mul();
        set_op(4'd7, 32'h3, 32'h5, 16'h0, 8'h10);
        step();
        set_idle();
        repeat (5) step();
        checks++; if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy: got %b want 1", bus.oBusy); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.oValid); end
        checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.oBusy); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.oReady); end
        set_op(4'd4, 32'h3, 32'h4, 16'h0, 8'h11);
        step();
        set_idle();
        checks++; if (bus.oResult !== 32'h7) begin errors++; $display("FAIL add_after_reset: got %h want 00000007", bus.oResult); end
        checks++; if (bus.oWriteEnable !== 1'b1) begin errors++; $display("FAIL add_after_reset_we: got %b want 1", bus.oWriteEnable); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.iResultReady = 1'b1;
        set_op(4'd4, 32'h5, 32'h3, 16'h0, 8'h01);
        step();
        checks++; if (bus.oResult !== 32'h0000_0008 || bus.oWriteEnable !== 1'b1)
            begin errors++; $display("FAIL b2b_add: got %h we=%b want 00000008 we=1", bus.oResult, bus.oWriteEnable); end
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.oReady); end
        set_op(4'd6, 32'h5, 32'h3, 16'h0, 8'h02);
        step();
        checks++; if (bus.oResult !== 32'h0000_FFFE || bus.oWriteEnable !== 1'b1 || bus.oDest !== 8'h02)
            begin errors++; $display("FAIL b2b_sub: got %h we=%b dest=%h want 0000fffe we=1 dest=02", bus.oResult, bus.oWriteEnable, bus.oDest); end
        set_op(4'd3, 32'h0, 32'h0, 16'h1234, 8'h03);
        step();
        checks++; if (bus.oResult !== 32'h0000_1234 || bus.oWriteEnable !== 1'b1)
            begin errors++; $display("FAIL b2b_sto: got %h we=%b want 00001234 we=1", bus.oResult, bus.oWriteEnable); end
        set_idle();
        step();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.oValid); end
    endtask

    task automatic test_multiply();
        logic [31:0] res;
        int          lat;
        logic        wide;
        logic        busy_mid;
        run_mul(4'd7, 16'hFFFE, 16'h0003, res, lat, wide, busy_mid);
        checks++; if (res !== 32'hFFFF_FFFA) begin errors++; $display("FAIL smul_neg: got %h want fffffffa", res); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL smul_latency: got %0d want 18", lat); end
        checks++; if (wide !== 1'b1) begin errors++; $display("FAIL smul_wide_we: got %b want 1", wide); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL smul_busy: got %b want 1", busy_mid); end
        run_mul(4'd7, 16'h8000, 16'h8000, res, lat, wide, busy_mid);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL smul_min_min: got %h want 40000000", res); end
        run_mul(4'd10, 16'hFFFF, 16'hFFFF, res, lat, wide, busy_mid);
        checks++; if (res !== 32'hFFFE_0001) begin errors++; $display("FAIL umul_max: got %h want fffe0001", res); end
        run_mul(4'd10, 16'h0000, 16'h1234, res, lat, wide, busy_mid);
        checks++; if (res !== 32'h0 || lat !== 18) begin errors++; $display("FAIL umul_zero: got %h lat=%0d want 0 lat=18", res, lat); end
    endtask

    task automatic test_backpressure();
        bus.iResultReady = 1'b0;
        set_op(4'd4, 32'h1, 32'h2, 16'h0, 8'h05);
        step();
        set_op(4'd3, 32'h0, 32'h0, 16'h55AA, 8'h06);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.oValid !== 1'b1 || bus.oResult !== 32'h3 || bus.oReady !== 1'b0)
                begin errors++; $display("FAIL bp_hold_%0d: valid=%b result=%h ready=%b want 1 00000003 0", i, bus.oValid, bus.oResult, bus.oReady); end
        end
        bus.iResultReady = 1'b1;
        #1;
        checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.oReady); end
        step();
        set_idle();
        checks++; if (bus.oResult !== 32'h55AA || bus.oDest !== 8'h06)
            begin errors++; $display("FAIL bp_next_op: got %h dest=%h want 000055aa dest=06", bus.oResult, bus.oDest); end
        step();
    endtask

    task automatic test_saturation();
        bus.iResultReady = 1'b1;
        set_op(4'd4, 32'h0001, 32'h7FFF, 16'h0, 8'h07);
        step();
        checks++; if (bus_sat.oResult !== 32'h7FFF) begin errors++; $display("FAIL sat_add: got %h want 00007fff", bus_sat.oResult); end
        checks++; if (bus.oResult !== 32'h8000) begin errors++; $display("FAIL wrap_add: got %h want 00008000", bus.oResult); end
        set_op(4'd6, 32'h0001, 32'h8000, 16'h0, 8'h08);
        step();
        checks++; if (bus_sat.oResult !== 32'h8000) begin errors++; $display("FAIL sat_sub: got %h want 00008000", bus_sat.oResult); end
        checks++; if (bus.oResult !== 32'h7FFF) begin errors++; $display("FAIL wrap_sub: got %h want 00007fff", bus.oResult); end
        set_op(4'd8, 32'h0000_0001, 32'h0000_FFFF, 16'h0, 8'h09);
        step();
        checks++; if (bus_sat.oResult !== 32'h0001_0000 || bus_sat.oWriteEnableWide !== 1'b1 || bus_sat.oWriteEnable !== 1'b0)
            begin errors++; $display("FAIL sat_add_w: got %h wew=%b we=%b want 00010000 1 0", bus_sat.oResult, bus_sat.oWriteEnableWide, bus_sat.oWriteEnable); end
        set_op(4'd9, 32'h0000_0001, 32'h0000_0000, 16'h0, 8'h0A);
        step();
        checks++; if (bus_sat.oResult !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_w: got %h want ffffffff", bus_sat.oResult); end
        set_idle();
        step();
    endtask

    task automatic test_control();
        bus.iResultReady = 1'b1;
        set_op(4'd2, 32'h2, 32'h2, 16'h0, 8'h40);
        step();
        checks++; if (bus.oBranchTaken !== 1'b1 || bus.oDest !== 8'h40)
            begin errors++; $display("FAIL ble_equal: br=%b dest=%h want 1 40", bus.oBranchTaken, bus.oDest); end
        set_op(4'd2, 32'h2, 32'h3, 16'h0, 8'h41);
        step();
        checks++; if (bus.oBranchTaken !== 1'b0 || bus.oValid !== 1'b1)
            begin errors++; $display("FAIL ble_greater: br=%b valid=%b want 0 1", bus.oBranchTaken, bus.oValid); end
        set_op(4'd5, 32'h0, 32'h0, 16'h0, 8'h42);
        step();
        checks++; if (bus.oBranchTaken !== 1'b1 || bus.oWriteEnable !== 1'b0)
            begin errors++; $display("FAIL jmp: br=%b we=%b want 1 0", bus.oBranchTaken, bus.oWriteEnable); end
        set_op(4'd1, 32'h0, 32'h00A5, 16'h0, 8'h43);
        step();
        checks++; if (bus.oLedEnable !== 1'b1 || bus.oResult[7:0] !== 8'hA5 || bus.oWriteEnable !== 1'b0)
            begin errors++; $display("FAIL led: led=%b res=%h we=%b want 1 a5 0", bus.oLedEnable, bus.oResult[7:0], bus.oWriteEnable); end
        set_op(4'hF, 32'h1, 32'h1, 16'h0, 8'h44);
        step();
        checks++; if (bus.oIllegal !== 1'b1 || {bus.oWriteEnable, bus.oWriteEnableWide, bus.oBranchTaken, bus.oLedEnable} !== 4'b0)
            begin errors++; $display("FAIL illegal: ill=%b en=%b want 1 0000", bus.oIllegal,
                {bus.oWriteEnable, bus.oWriteEnableWide, bus.oBranchTaken, bus.oLedEnable}); end
        set_op(4'd0, 32'h7, 32'h9, 16'h0, 8'h45);
        step();
        checks++; if (bus.oValid !== 1'b1 || bus.oResult !== 32'h0 || bus.oIllegal !== 1'b0 ||
                      {bus.oWriteEnable, bus.oWriteEnableWide, bus.oBranchTaken, bus.oLedEnable} !== 4'b0)
            begin errors++; $display("FAIL nop: valid=%b res=%h ill=%b want 1 0 0", bus.oValid, bus.oResult, bus.oIllegal); end
        set_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_back_to_back();
        test_multiply();
        test_backpressure();
        test_saturation();
        test_control();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
